// File: rtl/safecrack_lock_ctrl.sv
// safecrack_lock_ctrl
// N-digit, W-button combination lock controller with edge-detected entry,
// error-count lockout timed by a self-derived seconds tick, and atomic code
// reprogramming through a shadow register.
//
// Ports:
//   clk           system clock (CLK_HZ cycles per lockout second)
//   rst           synchronous active-high reset
//   i_ms          code-change mode request (level)
//   i_btn         active-low debounced buttons, all-ones = no press
//   o_unlocked    high while UNLOCKED
//   o_locked_out  high while LOCKOUT
//   o_code_saved  one-cycle pulse when a new code is committed
//   o_leds_err    thermometer of the wrong-digit count
//   o_leds_ok     thermometer of correct digits so far (all ones when open)
//   o_leds_sec    thermometer of elapsed lockout seconds
//
// Inputs are registered once before use, so a press sampled at edge t is
// acted on at edge t+1 and no output depends combinationally on i_btn/i_ms.
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_ENTRY    | scoring presses against the active code
// S_UNLOCKED | code accepted; press relocks, ms enters programming
// S_PROG     | collecting a new code into the shadow register
// S_LOCKOUT  | too many errors; inputs ignored until timer expires

module safecrack_lock_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int NUM_BTN  = 4,
  parameter int CODE_LEN = 3,
  parameter int MAX_ERR  = 3,
  parameter int LOCK_SEC = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ms,
  input  logic [NUM_BTN-1:0]  i_btn,
  output logic                o_unlocked,
  output logic                o_locked_out,
  output logic                o_code_saved,
  output logic [MAX_ERR-1:0]  o_leds_err,
  output logic [CODE_LEN-1:0] o_leds_ok,
  output logic [LOCK_SEC-1:0] o_leds_sec
);

  localparam int IDX_W = $clog2(CODE_LEN + 1);
  localparam int ERR_W = $clog2(MAX_ERR + 1);
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(MAX_ERR - 1);
  localparam logic [ERR_W-1:0] ERR_FULL = ERR_W'(MAX_ERR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [3:0]       SEC_LAST = 4'(LOCK_SEC - 1);

  typedef enum logic [1:0] {
    S_ENTRY    = 2'd0,
    S_UNLOCKED = 2'd1,
    S_PROG     = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  // Default digit i is one-cold at bit (i mod NUM_BTN).
  function automatic logic [NUM_BTN-1:0] default_digit(input int i);
    return ~(NUM_BTN'(1) << (i % NUM_BTN));
  endfunction

  state_t             r_state;
  logic [NUM_BTN-1:0] r_btn;
  logic [NUM_BTN-1:0] r_btn_d;
  logic               r_ms;
  logic [NUM_BTN-1:0] r_code   [CODE_LEN];
  logic [NUM_BTN-1:0] r_shadow [CODE_LEN];
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_pidx;
  logic [ERR_W-1:0]   r_err;
  logic [3:0]         r_sec;
  logic [DIV_W-1:0]   r_div;

  logic               w_press;
  logic [NUM_BTN-1:0] w_inv;
  logic               w_one_cold;
  logic               w_match;
  logic [CODE_LEN-1:0] w_ok_therm;

  // Event only on the released->pressed transition, so a held button counts once.
  assign w_press    = (~&r_btn) && (&r_btn_d);
  // Exactly one zero bit: inverted value is a nonzero power of two.
  assign w_inv      = ~r_btn;
  assign w_one_cold = (w_inv != '0) && ((w_inv & (w_inv - 1'b1)) == '0);
  assign w_match    = w_one_cold && (r_btn == r_code[r_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_ENTRY;
      r_btn        <= '1;
      r_btn_d      <= '1;
      r_ms         <= 1'b0;
      r_idx        <= '0;
      r_pidx       <= '0;
      r_err        <= '0;
      r_sec        <= '0;
      r_div        <= '0;
      o_unlocked   <= 1'b0;
      o_locked_out <= 1'b0;
      o_code_saved <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
        r_code[i]   <= default_digit(i);
        r_shadow[i] <= '1;
      end
    end else begin
      r_btn        <= i_btn;
      r_btn_d      <= r_btn;
      r_ms         <= i_ms;
      o_code_saved <= 1'b0;

      case (r_state)
        S_ENTRY: begin
          if (w_press) begin
            if (w_match) begin
              if (r_idx == IDX_LAST) begin
                r_state    <= S_UNLOCKED;
                o_unlocked <= 1'b1;
                r_idx      <= '0;
                r_err      <= '0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              // A wrong digit always restarts the code from the first digit.
              r_idx <= '0;
              if (r_err == ERR_LAST) begin
                r_err        <= ERR_FULL;
                r_state      <= S_LOCKOUT;
                o_locked_out <= 1'b1;
              end else begin
                r_err <= r_err + 1'b1;
              end
            end
          end
        end

        S_UNLOCKED: begin
          // ms has priority: a press arriving together with ms is dropped.
          if (r_ms) begin
            r_state    <= S_PROG;
            r_pidx     <= '0;
            o_unlocked <= 1'b0;
          end else if (w_press) begin
            r_state    <= S_ENTRY;
            r_idx      <= '0;
            o_unlocked <= 1'b0;
          end
        end

        S_PROG: begin
          // Abort outranks a final digit arriving in the same cycle.
          if (!r_ms) begin
            r_state    <= S_UNLOCKED;
            r_pidx     <= '0;
            o_unlocked <= 1'b1;
          end else if (w_press && w_one_cold) begin
            r_shadow[r_pidx] <= r_btn;
            if (r_pidx == IDX_LAST) begin
              // Final digit goes straight into the active code alongside the
              // earlier shadow digits so the whole code switches in one edge.
              for (int i = 0; i < CODE_LEN; i++) begin
                r_code[i] <= (i == CODE_LEN - 1) ? r_btn : r_shadow[i];
              end
              o_code_saved <= 1'b1;
              r_state      <= S_ENTRY;
              r_pidx       <= '0;
              r_idx        <= '0;
            end else begin
              r_pidx <= r_pidx + 1'b1;
            end
          end
        end

        S_LOCKOUT: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            // Leave on the LOCK_SEC-th tick, so the top seconds LED never lights.
            if (r_sec == SEC_LAST) begin
              r_sec        <= '0;
              r_err        <= '0;
              r_state      <= S_ENTRY;
              o_locked_out <= 1'b0;
            end else begin
              r_sec <= r_sec + 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end

        default: begin
          r_state <= S_ENTRY;
        end
      endcase
    end
  end

  for (genvar k = 0; k < MAX_ERR; k++) begin : g_err
    assign o_leds_err[k] = (32'(r_err) > k);
  end

  for (genvar k = 0; k < CODE_LEN; k++) begin : g_ok
    assign w_ok_therm[k] = (32'(r_idx) > k);
  end

  for (genvar k = 0; k < LOCK_SEC; k++) begin : g_sec
    assign o_leds_sec[k] = (32'(r_sec) > k);
  end

  assign o_leds_ok = (r_state == S_ENTRY)   ? w_ok_therm :
                     (r_state == S_LOCKOUT) ? '0         : '1;

endmodule

// File: tb/tb_safecrack_lock_ctrl.sv
// Directed testbench for safecrack_lock_ctrl with CLK_HZ=4, NUM_BTN=4,
// CODE_LEN=3, MAX_ERR=3, LOCK_SEC=10. Inputs change and outputs are checked
// 1 ns after each rising edge. A press needs two edges to show on outputs.

module tb_safecrack_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ms;
  logic [3:0] btn;
  logic       unlocked;
  logic       locked_out;
  logic       code_saved;
  logic [2:0] leds_err;
  logic [2:0] leds_ok;
  logic [9:0] leds_sec;

  int checks   = 0;
  int failures = 0;

  safecrack_lock_ctrl #(
    .CLK_HZ  (4),
    .NUM_BTN (4),
    .CODE_LEN(3),
    .MAX_ERR (3),
    .LOCK_SEC(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_ms        (ms),
    .i_btn       (btn),
    .o_unlocked  (unlocked),
    .o_locked_out(locked_out),
    .o_code_saved(code_saved),
    .o_leds_err  (leds_err),
    .o_leds_ok   (leds_ok),
    .o_leds_sec  (leds_sec)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    btn = v;
    step(1);
    btn = 4'hF;
    step(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic unl, input logic lo,
                        input logic cs, input logic [2:0] err,
                        input logic [2:0] ok, input logic [9:0] sec);
    chk({tag, ".unlocked"},   32'(unlocked),   32'(unl));
    chk({tag, ".locked_out"}, 32'(locked_out), 32'(lo));
    chk({tag, ".code_saved"}, 32'(code_saved), 32'(cs));
    chk({tag, ".leds_err"},   32'(leds_err),   32'(err));
    chk({tag, ".leds_ok"},    32'(leds_ok),    32'(ok));
    chk({tag, ".leds_sec"},   32'(leds_sec),   32'(sec));
  endtask

  initial begin
    rst = 1'b1;
    ms  = 1'b0;
    btn = 4'hF;
    step(2);
    chk_st("in_reset", 0, 0, 0, 3'b000, 3'b000, 10'h000);
    rst = 1'b0;
    step(1);
    chk_st("reset", 0, 0, 0, 3'b000, 3'b000, 10'h000);

    // Correct entry with a long hold on the first digit
    btn = 4'hE;
    step(20);
    chk_st("hold", 0, 0, 0, 3'b000, 3'b001, 10'h000);
    btn = 4'hF;
    step(1);
    press(4'hD);
    chk_st("digit2", 0, 0, 0, 3'b000, 3'b011, 10'h000);
    press(4'hB);
    chk_st("unlock1", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    // Relock press is not scored
    press(4'h7);
    chk_st("relock1", 0, 0, 0, 3'b000, 3'b000, 10'h000);

    // Error restart
    press(4'hE);
    chk_st("err_d1", 0, 0, 0, 3'b000, 3'b001, 10'h000);
    press(4'h7);
    chk_st("err_wrong", 0, 0, 0, 3'b001, 3'b000, 10'h000);
    press(4'hE);
    press(4'hD);
    press(4'hB);
    chk_st("unlock2", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    // Lockout: three wrong digits, then 40 cycles of 4-cycle seconds
    press(4'hE);
    chk_st("relock2", 0, 0, 0, 3'b000, 3'b000, 10'h000);
    press(4'h7);
    press(4'hB);
    chk_st("err2", 0, 0, 0, 3'b011, 3'b000, 10'h000);
    press(4'hD);
    chk_st("lock0", 0, 1, 0, 3'b111, 3'b000, 10'h000);
    step(3);
    chk_st("lock3", 0, 1, 0, 3'b111, 3'b000, 10'h000);
    step(1);
    chk_st("lock4", 0, 1, 0, 3'b111, 3'b000, 10'h001);
    step(4);
    chk_st("lock8", 0, 1, 0, 3'b111, 3'b000, 10'h003);
    ms = 1'b1;
    press(4'hE);
    press(4'h7);
    ms = 1'b0;
    chk_st("lock12_ign", 0, 1, 0, 3'b111, 3'b000, 10'h007);
    step(27);
    chk_st("lock39", 0, 1, 0, 3'b111, 3'b000, 10'h1FF);
    step(1);
    chk_st("lock40", 0, 0, 0, 3'b000, 3'b000, 10'h000);

    // Reprogram to 0111, 0111, 1101
    press(4'hE);
    press(4'hD);
    press(4'hB);
    chk_st("unlock3", 1, 0, 0, 3'b000, 3'b111, 10'h000);
    ms = 1'b1;
    step(2);
    chk_st("prog", 0, 0, 0, 3'b000, 3'b111, 10'h000);
    press(4'h7);
    press(4'h7);
    chk_st("prog2", 0, 0, 0, 3'b000, 3'b111, 10'h000);
    press(4'hD);
    chk_st("commit", 0, 0, 1, 3'b000, 3'b000, 10'h000);
    ms = 1'b0;
    step(1);
    chk_st("commit1", 0, 0, 0, 3'b000, 3'b000, 10'h000);
    press(4'hE);
    chk_st("oldfail", 0, 0, 0, 3'b001, 3'b000, 10'h000);
    press(4'h7);
    chk_st("new_d1", 0, 0, 0, 3'b001, 3'b001, 10'h000);
    press(4'h7);
    press(4'hD);
    chk_st("newcode", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    // Abort mid-programming
    ms = 1'b1;
    step(2);
    press(4'hE);
    ms = 1'b0;
    step(1);
    chk_st("abort_wait", 0, 0, 0, 3'b000, 3'b111, 10'h000);
    step(1);
    chk_st("abort", 1, 0, 0, 3'b000, 3'b111, 10'h000);
    press(4'hB);
    chk_st("relock3", 0, 0, 0, 3'b000, 3'b000, 10'h000);
    press(4'h7);
    press(4'h7);
    press(4'hD);
    chk_st("after_abort", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    // ms falls together with the final digit: abort wins
    ms = 1'b1;
    step(2);
    press(4'hE);
    press(4'hE);
    btn = 4'hD;
    ms  = 1'b0;
    step(1);
    btn = 4'hF;
    step(1);
    chk_st("simul", 1, 0, 0, 3'b000, 3'b111, 10'h000);
    press(4'hE);
    press(4'h7);
    press(4'h7);
    press(4'hD);
    chk_st("simul_code", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    // Multi-button press is a wrong digit
    press(4'hE);
    press(4'hC);
    chk_st("multi", 0, 0, 0, 3'b001, 3'b000, 10'h000);
    press(4'h7);
    press(4'h7);
    press(4'hD);
    chk_st("unlock4", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    // Reset mid-PROG restores the default code
    ms = 1'b1;
    step(2);
    press(4'hE);
    rst = 1'b1;
    step(1);
    chk_st("rst_prog", 0, 0, 0, 3'b000, 3'b000, 10'h000);
    rst = 1'b0;
    ms  = 1'b0;
    step(1);
    press(4'hE);
    press(4'hD);
    press(4'hB);
    chk_st("default1", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    // Reset mid-LOCKOUT
    press(4'h7);
    press(4'h7);
    press(4'h7);
    press(4'h7);
    chk_st("lock2", 0, 1, 0, 3'b111, 3'b000, 10'h000);
    step(5);
    chk_st("lock2_5", 0, 1, 0, 3'b111, 3'b000, 10'h001);
    rst = 1'b1;
    step(1);
    chk_st("rst_lock", 0, 0, 0, 3'b000, 3'b000, 10'h000);
    rst = 1'b0;
    step(1);
    press(4'hE);
    press(4'hD);
    press(4'hB);
    chk_st("default2", 1, 0, 0, 3'b000, 3'b111, 10'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
